// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable serial pattern-detect controller.
// Optional build macro: SEQ_DETECT_NONOVERLAP_EN (non-overlapping match counting).
package seq_detect_pkg;

    // Default sizing for the controller and its datapath
    localparam int unsigned PAT_W_DEF = 32'd8;
    localparam int unsigned FRM_W_DEF = 32'd16;
    localparam int unsigned CNT_W_DEF = 32'd8;

    // Frame-level controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Map a raw pattern length onto the legal range 1..max_len
    function automatic int unsigned norm_len(input int unsigned raw_len,
                                             input int unsigned max_len);
        int unsigned res;
        if (raw_len == 32'd0) begin
            res = 32'd1;
        end else if (raw_len > max_len) begin
            res = max_len;
        end else begin
            res = raw_len;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_shift_match.sv
// Serial history shift register, fill counter and Mealy pattern compare.
// With SEQ_DETECT_NONOVERLAP_EN defined the fill counter restarts on every
// match so consecutive matches never share bits.
module seq_shift_match
    import seq_detect_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             run_i,
    input  logic             valid_i,
    input  logic             a_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             y_o
);

    logic [PAT_W-1:0] hist_q;
    logic [LEN_W-1:0] hist_cnt_q;

    logic [PAT_W-1:0] cand_s;
    logic [PAT_W-1:0] len_mask_s;
    logic [LEN_W-1:0] need_s;
    logic             fill_ok_s;
    logic             bits_eq_s;
    logic             hit_s;

    // Candidate word (history plus current bit) compared against the low len bits of the pattern
    always_comb begin
        cand_s     = {hist_q[PAT_W-2:0], a_i};
        len_mask_s = '0;
        for (int i = 0; i < int'(PAT_W); i++) begin
            if (LEN_W'(i) < len_i) begin
                len_mask_s[i] = 1'b1;
            end else begin
                len_mask_s[i] = 1'b0;
            end
        end
        // len_i is always normalised to at least one, so this never wraps
        need_s    = len_i - LEN_W'(1);
        fill_ok_s = (hist_cnt_q >= need_s);
        bits_eq_s = (((cand_s ^ pattern_i) & len_mask_s) == '0);
        // Reset gates the output so Y is quiet for the whole reset-low window
        hit_s     = rst_n & run_i & valid_i & fill_ok_s & bits_eq_s;
    end

    assign y_o = hit_s;

    // History and fill count advance only on qualified bits while running
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q     <= '0;
            hist_cnt_q <= '0;
        end else if (clear_i) begin
            hist_q     <= '0;
            hist_cnt_q <= '0;
        end else if (run_i && valid_i) begin
            hist_q <= cand_s;
`ifdef SEQ_DETECT_NONOVERLAP_EN
            if (hit_s) begin
                hist_cnt_q <= '0;
            end else if (hist_cnt_q < LEN_W'(PAT_W)) begin
                hist_cnt_q <= hist_cnt_q + LEN_W'(1);
            end else begin
                hist_cnt_q <= hist_cnt_q;
            end
`else
            if (hist_cnt_q < LEN_W'(PAT_W)) begin
                hist_cnt_q <= hist_cnt_q + LEN_W'(1);
            end else begin
                hist_cnt_q <= hist_cnt_q;
            end
`endif
        end else begin
            hist_q     <= hist_q;
            hist_cnt_q <= hist_cnt_q;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run-time programmable serial pattern-detect controller: arms on start,
// counts Mealy matches over a frame of qualified bits, then pulses done.
// Optional build macro: SEQ_DETECT_NONOVERLAP_EN (non-overlapping counting,
// implemented inside seq_shift_match; the port list is identical either way).
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned FRM_W = FRM_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [PAT_W-1:0]     cfg_pattern,
    input  logic [$clog2(PAT_W):0] cfg_len,
    input  logic [FRM_W-1:0]     cfg_frame_len,
    input  logic                 in_valid,
    input  logic                 A,
    output logic                 Y,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     match_cnt
);

    localparam int unsigned LEN_W = $clog2(PAT_W) + 1;

    state_t           state_q;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [FRM_W-1:0] frame_len_q;
    logic [FRM_W-1:0] bit_idx_q;
    logic [CNT_W-1:0] match_cnt_q;
    logic             busy_q;
    logic             done_q;

    logic [LEN_W-1:0] len_norm_s;
    logic [FRM_W-1:0] frame_norm_s;
    logic             run_s;
    logic             start_ok_s;
    logic             last_bit_s;
    logic [FRM_W-1:0] bit_idx_d;
    logic [CNT_W-1:0] match_cnt_d;
    logic             y_s;

    // Configuration normalisation, start qualification and counter next values
    always_comb begin
        len_norm_s = LEN_W'(norm_len(32'(cfg_len), PAT_W));
        if (cfg_frame_len == '0) begin
            frame_norm_s = FRM_W'(1);
        end else begin
            frame_norm_s = cfg_frame_len;
        end
        run_s = (state_q == ST_RUN);
        // abort beats start; start is only honoured while not running
        start_ok_s = start & ~abort & ((state_q == ST_IDLE) | (state_q == ST_DONE));
        last_bit_s = (bit_idx_q == (frame_len_q - FRM_W'(1)));
        bit_idx_d  = bit_idx_q + FRM_W'(1);
        if (y_s && (match_cnt_q != {CNT_W{1'b1}})) begin
            match_cnt_d = match_cnt_q + CNT_W'(1);
        end else begin
            match_cnt_d = match_cnt_q;
        end
    end

    seq_shift_match #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shift_match (
        .clk       (clk),
        .rst_n     (reset),
        .clear_i   (start_ok_s),
        .run_i     (run_s),
        .valid_i   (in_valid),
        .a_i       (A),
        .pattern_i (pat_q),
        .len_i     (len_q),
        .y_o       (y_s)
    );

    // Frame FSM with registered busy/done/match count
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pat_q       <= '0;
            len_q       <= LEN_W'(1);
            frame_len_q <= FRM_W'(1);
            bit_idx_q   <= '0;
            match_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_ok_s) begin
                        state_q     <= ST_RUN;
                        busy_q      <= 1'b1;
                        pat_q       <= cfg_pattern;
                        len_q       <= len_norm_s;
                        frame_len_q <= frame_norm_s;
                        bit_idx_q   <= '0;
                        match_cnt_q <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        // match count is kept for the host to read
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (in_valid) begin
                        bit_idx_q   <= bit_idx_d;
                        match_cnt_q <= match_cnt_d;
                        if (last_bit_s) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Y         = y_s;
    assign busy      = busy_q;
    assign done      = done_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: table-driven frames plus
// hand-written sequences for abort, start collisions, saturation and reset.
module tb_seq_detect_ctrl;

    localparam int PAT_W = 8;
    localparam int FRM_W = 16;
    localparam int CNT_W = 8;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic [FRM_W-1:0] cfg_frame_len;
    logic             in_valid;
    logic             A;
    logic             Y;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_cnt;

    seq_detect_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .cfg_pattern   (cfg_pattern),
        .cfg_len       (cfg_len),
        .cfg_frame_len (cfg_frame_len),
        .in_valid      (in_valid),
        .A             (A),
        .Y             (Y),
        .busy          (busy),
        .done          (done),
        .match_cnt     (match_cnt)
    );

    always #5 clk = ~clk;

    int nchk  = 0;
    int nfail = 0;

    // Scoreboards: per-bit Mealy expectations and per-frame final counts
    logic       yq[$];
    logic [7:0] cq[$];

    // Reference model of the detector
    logic       mhist[$];
    int         mcnt;
    int         mlen;
    logic [7:0] mpat;

    typedef struct {
        logic [7:0]  pat;
        logic [3:0]  len;
        logic [15:0] flen;
        int          ncyc;
        logic [31:0] vld;
        logic [31:0] dat;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int norm(input int raw);
        if (raw == 0) return 1;
        if (raw > PAT_W) return PAT_W;
        return raw;
    endfunction

    task automatic model_start(input logic [7:0] p, input int l);
        mpat = p;
        mlen = norm(l);
        mhist.delete();
        mcnt = 0;
    endtask

    // Expected Y for current bit a: last mlen received bits must spell the pattern MSB-first
    function automatic logic model_y(input logic a);
        logic ok;
        ok = (mcnt >= mlen - 1) && (a == mpat[0]);
        for (int k = 1; k < mlen; k++) begin
            if (mhist.size() < k) ok = 1'b0;
            else if (mhist[mhist.size() - k] != mpat[k]) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic model_shift(input logic a, input logic y);
        mhist.push_back(a);
        if (mhist.size() > PAT_W) void'(mhist.pop_front());
`ifdef SEQ_DETECT_NONOVERLAP_EN
        if (y) mcnt = 0;
        else if (mcnt < PAT_W) mcnt++;
`else
        if (mcnt < PAT_W) mcnt++;
`endif
    endtask

    // Stream string: '1'/'0' valid bits, '-' a gap cycle (in_valid low, A high)
    function automatic void set_stream(input int idx, input string s);
        byte c;
        vecs[idx].ncyc = s.len();
        vecs[idx].vld  = '0;
        vecs[idx].dat  = '0;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == 8'h2d) begin
                vecs[idx].dat[i] = 1'b1;
            end else begin
                vecs[idx].vld[i] = 1'b1;
                vecs[idx].dat[i] = (c == 8'h31);
            end
        end
    endfunction

    // All tasks below start and end on a falling edge
    task automatic start_frame(input logic [7:0] p, input logic [3:0] l, input logic [15:0] f);
        start = 1'b1; cfg_pattern = p; cfg_len = l; cfg_frame_len = f; in_valid = 1'b0;
        model_start(p, int'(l));
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("cnt_after_start", 32'(match_cnt), 32'd0);
    endtask

    task automatic drive_bit(input logic v, input logic a, input string tag);
        logic ey;
        in_valid = v; A = a;
        ey = v ? model_y(a) : 1'b0;
        yq.push_back(ey);
        #1;
        if (yq.size() == 0) begin
            chk({tag, "_yq_empty"}, 32'd1, 32'd0);
        end else begin
            chk({tag, "_Y"}, 32'(Y), 32'(yq.pop_front()));
        end
        if (v) model_shift(a, ey);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_done(input string tag);
        in_valid = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        if (cq.size() == 0) begin
            chk({tag, "_cq_empty"}, 32'd1, 32'd0);
        end else begin
            chk({tag, "_cnt"}, 32'(match_cnt), 32'(cq.pop_front()));
        end
        @(negedge clk);
        chk({tag, "_done_pulse_end"}, 32'(done), 32'd0);
    endtask

    task automatic run_vec(input int i);
        start_frame(vecs[i].pat, vecs[i].len, vecs[i].flen);
        cq.push_back(vecs[i].exp_cnt);
        for (int c = 0; c < vecs[i].ncyc; c++) begin
            drive_bit(vecs[i].vld[c], vecs[i].dat[c], $sformatf("vec%0d_b%0d", i, c));
        end
        expect_done($sformatf("vec%0d", i));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Frame table
        vecs[0].pat = 8'h07; vecs[0].len = 4'd3;  vecs[0].flen = 16'd11; set_stream(0, "00111011110");
        vecs[1].pat = 8'h0B; vecs[1].len = 4'd4;  vecs[1].flen = 16'd8;  set_stream(1, "10-110-110");
`ifdef SEQ_DETECT_NONOVERLAP_EN
        vecs[0].exp_cnt = 8'd2;
        vecs[1].exp_cnt = 8'd1;
`else
        vecs[0].exp_cnt = 8'd3;
        vecs[1].exp_cnt = 8'd2;
`endif
        vecs[2].pat = 8'h01; vecs[2].len = 4'd0;  vecs[2].flen = 16'd4;  set_stream(2, "1011");
        vecs[2].exp_cnt = 8'd3;
        vecs[3].pat = 8'hA6; vecs[3].len = 4'd12; vecs[3].flen = 16'd10; set_stream(3, "1010011010");
        vecs[3].exp_cnt = 8'd1;
        vecs[4].pat = 8'h01; vecs[4].len = 4'd1;  vecs[4].flen = 16'd0;  set_stream(4, "1");
        vecs[4].exp_cnt = 8'd1;

        // Power-up reset with live-looking inputs
        reset = 1'b0; start = 1'b0; abort = 1'b0; cfg_pattern = 8'h01; cfg_len = 4'd1;
        cfg_frame_len = 16'd4; in_valid = 1'b1; A = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_Y", 32'(Y), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cnt", 32'(match_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(i);

        // abort after 3 bits: no done, count holds, IDLE
        start_frame(8'h01, 4'd1, 16'd10);
        for (int b = 0; b < 3; b++) drive_bit(1'b1, 1'b1, "abort_seq");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_cnt", 32'(match_cnt), 32'd3);
        @(negedge clk);
        chk("abort_done_later", 32'(done), 32'd0);
        chk("abort_cnt_hold", 32'(match_cnt), 32'd3);
        in_valid = 1'b1; A = 1'b1;
        #1;
        chk("idle_Y", 32'(Y), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;

        // start while running is ignored
        start_frame(8'h01, 4'd1, 16'd3);
        cq.push_back(8'd3);
        drive_bit(1'b1, 1'b1, "srun_b0");
        start = 1'b1; cfg_frame_len = 16'd100; cfg_pattern = 8'h00;
        drive_bit(1'b1, 1'b1, "srun_b1");
        start = 1'b0;
        chk("srun_cnt_mid", 32'(match_cnt), 32'd2);
        chk("srun_busy_mid", 32'(busy), 32'd1);
        drive_bit(1'b1, 1'b1, "srun_b2");
        expect_done("srun");

        // start with abort in IDLE stays idle
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("sa_idle_busy", 32'(busy), 32'd0);

        // start with abort in RUN ends the frame without done
        start_frame(8'h01, 4'd1, 16'd5);
        drive_bit(1'b1, 1'b1, "sa_run_b0");
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("sa_run_busy", 32'(busy), 32'd0);
        chk("sa_run_done", 32'(done), 32'd0);
        chk("sa_run_cnt", 32'(match_cnt), 32'd1);

        // start in DONE: done still pulses and a new frame begins
        start_frame(8'h01, 4'd1, 16'd1);
        drive_bit(1'b1, 1'b1, "sdone_b0");
        chk("sdone_done", 32'(done), 32'd1);
        chk("sdone_cnt", 32'(match_cnt), 32'd1);
        start_frame(8'h01, 4'd1, 16'd2);
        chk("sdone_done_cleared", 32'(done), 32'd0);
        cq.push_back(8'd2);
        drive_bit(1'b1, 1'b1, "sdone2_b0");
        drive_bit(1'b1, 1'b1, "sdone2_b1");
        expect_done("sdone2");

        // Saturation of the match counter
        start_frame(8'h01, 4'd1, 16'd300);
        cq.push_back(8'd255);
        for (int b = 0; b < 300; b++) drive_bit(1'b1, 1'b1, "sat");
        expect_done("sat");

        // Reset mid-frame then a clean frame
        start_frame(8'h01, 4'd1, 16'd20);
        for (int b = 0; b < 5; b++) drive_bit(1'b1, 1'b1, "mrst");
        reset = 1'b0; in_valid = 1'b1; A = 1'b1;
        #1;
        chk("mrst_Y", 32'(Y), 32'd0);
        @(negedge clk);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_cnt", 32'(match_cnt), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        run_vec(0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
